mips_controller: RTL and testbench
==================================

Name: mips_controller

Overview:
- Multicycle control FSM for the 8-bit MIPS datapath.
- Sequences the four-byte instruction fetch, then decode, execute, memory access and writeback.
- Decodes opcode/funct from the datapath instruction register.
- Drives every datapath control input plus the memory read/write strobes; sole owner of datapath sequencing.

Parameters:
- INVALID_OP_HALT, 0, 0: unknown opcode in DECODE returns to FETCH1. 1: enters HALT, which exits only on reset.

Ports:
- clk  input  1  system clock, all state changes on rising edge
- reset  input  1  synchronous, active-low; reset==0 at a rising edge forces FETCH1
- op  input  6  instr[31:26] from datapath
- funct  input  6  instr[5:0] from datapath
- zero  input  1  datapath zero-detect; 1 = operands equal
- alucontrol  output  3  ALU operation
- alusrca  output  1  0 = PC, 1 = register A
- alusrcb  output  2  00 = B, 01 = constant 1, 10 = instr[7:0], 11 = constx4
- iord  output  1  0 = PC address, 1 = aluout address
- irwrite  output  4  one-hot byte enable; bit0 loads instr[31:24]
- memtoreg  output  1  1 = memory data to regfile WD, 0 = aluout
- pcen  output  1  PC register enable
- pcsource  output  2  00 = aluresult, 01 = aluout, 10 = constx4, 11 unused (never driven)
- regdst  output  1  1 = rd (instr[13:11]), 0 = rt (instr[18:16])
- regwrite  output  1  regfile write enable
- memread  output  1  memory read strobe
- memwrite  output  1  memory write strobe

Behaviour:
- Moore FSM: state register plus combinational output decode from state; op/funct/zero affect only next state, alucontrol and pcen.
- Internal signals: pcwrite, branch, aluop[1:0]. pcen = pcwrite | (branch & zero).
- Reset: state = FETCH1. Outputs take FETCH1 values immediately after the edge.
- Any output not listed for a state is 0. Defaults: alucontrol=010, pcsource=00, irwrite=0000.
- FETCH1..FETCH4: memread=1, alusrca=0, alusrcb=01, aluop=00, pcwrite=1, pcsource=00. irwrite = 0001/0010/0100/1000 respectively. Advances unconditionally FETCH1 → FETCH2 → FETCH3 → FETCH4 → DECODE.
- DECODE: alusrca=0, alusrcb=11, aluop=00 (precomputes branch target into aluout). Next state by op:
  - 100000 (LB) → MEMADR
  - 101000 (SB) → MEMADR
  - 000000 (R-type) → RTYPEEX
  - 000100 (BEQ) → BEQEX
  - 000010 (J) → JEX
  - any other → FETCH1, or HALT if INVALID_OP_HALT=1
- MEMADR: alusrca=1, alusrcb=10, aluop=00. op=100000 → LBRD; otherwise → SBWR.
- LBRD: memread=1, iord=1 → LBWR.
- LBWR: regwrite=1, memtoreg=1, regdst=0 → FETCH1.
- SBWR: memwrite=1, iord=1 → FETCH1.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10 → RTYPEWR.
- RTYPEWR: regwrite=1, regdst=1, memtoreg=0 → FETCH1.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, branch=1, pcsource=01 → FETCH1. pcen follows zero in the same cycle.
- JEX: pcwrite=1, pcsource=10 → FETCH1.
- HALT: all outputs 0; stays in HALT until reset.
- ALU decode:
  - aluop 00 → 010 (add); 01 → 110 (sub); 11 unused → 010.
  - aluop 10 → by funct: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111, any other → 010.
- Latency in cycles including fetch: LB 8, SB 7, R-type 7, BEQ 6, J 6.
- reset low in any state, including mid-fetch or during memwrite, takes precedence: FETCH1 next cycle and no further strobes from the aborted instruction.
- Illegal or unreachable state encodings → FETCH1.

Optional Feature:
- MIPS_ADDI_EN defined: op 001000 in DECODE → ADDIEX, then ADDIWR.
  - ADDIEX: alusrca=1, alusrcb=10, aluop=00 → ADDIWR.
  - ADDIWR: regwrite=1, regdst=0, memtoreg=0 → FETCH1.
  - ADDI latency 7 cycles.
- Undefined: op 001000 is an unknown opcode, handled per INVALID_OP_HALT. ADDIEX/ADDIWR are not instantiated.

Decomposition:
- Package mips_ctrl_pkg:
  - state typedef (FETCH1..FETCH4, DECODE, MEMADR, LBRD, LBWR, SBWR, RTYPEEX, RTYPEWR, BEQEX, JEX, ADDIEX, ADDIWR, HALT)
  - opcode constants (OP_LB, OP_SB, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI)
  - funct constants
  - aluop constants
  - alucontrol constants
- One sub-module: mips_aludec (aluop + funct → alucontrol), purely combinational.

Test Plan:
- reset=0 held 2 cycles, then released → state FETCH1; memread=1, irwrite=0001, pcen=1, alusrcb=01. Next three cycles irwrite=0010, 0100, 1000.
- op=000000, funct=100010 → RTYPEEX shows alucontrol=110, alusrca=1, alusrcb=00. RTYPEWR shows regwrite=1, regdst=1. Then FETCH1.
- op=100000 → MEMADR, LBRD (memread=1, iord=1), LBWR (regwrite=1, memtoreg=1, regdst=0); 8 cycles total. Repeat with op=101000 → SBWR with memwrite=1, iord=1.
- op=000100 in BEQEX: with zero=1 → pcen=1, pcsource=01. With zero=0 → pcen=0. op=000010 → JEX with pcen=1, pcsource=10.
- op=111111 → FETCH1 after DECODE when INVALID_OP_HALT=0; HALT with all outputs 0 when INVALID_OP_HALT=1. Also: op=001000 with MIPS_ADDI_EN defined → ADDIWR with regwrite=1, regdst=0.
- reset=0 asserted during SBWR → memwrite=0 from the next cycle and state=FETCH1.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit.
//   state_t      : controller states (ADDIEX/ADDIWR reachable only with MIPS_ADDI_EN)
//   OP_*         : opcode field values, instr[31:26]
//   FUNCT_*      : R-type function field values, instr[5:0]
//   ALUOP_*      : controller-to-ALU-decoder operation class
//   ALU_*        : ALU operation select driven onto alucontrol
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH1  = 4'd0,
        FETCH2  = 4'd1,
        FETCH3  = 4'd2,
        FETCH4  = 4'd3,
        DECODE  = 4'd4,
        MEMADR  = 4'd5,
        LBRD    = 4'd6,
        LBWR    = 4'd7,
        SBWR    = 4'd8,
        RTYPEEX = 4'd9,
        RTYPEWR = 4'd10,
        BEQEX   = 4'd11,
        JEX     = 4'd12,
        ADDIEX  = 4'd13,
        ADDIWR  = 4'd14,
        HALT    = 4'd15
    } state_t;

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_aludec.sv
// ALU decoder: maps the controller's operation class plus the R-type
// function field onto the ALU operation select. Purely combinational.
//   aluop      in  2  operation class (add / sub / use funct)
//   funct      in  6  instr[5:0]
//   alucontrol out 3  ALU operation select
module mips_aludec
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alucontrol = ALU_ADD;
                    FUNCT_SUB: alucontrol = ALU_SUB;
                    FUNCT_AND: alucontrol = ALU_AND;
                    FUNCT_OR:  alucontrol = ALU_OR;
                    FUNCT_SLT: alucontrol = ALU_SLT;
                    default:   alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_controller.sv
// Multicycle control FSM for the 8-bit MIPS datapath: four-byte fetch,
// decode, execute, memory access and writeback.
// Optional feature macro: MIPS_ADDI_EN adds ADDI (ADDIEX -> ADDIWR).
//   clk        in  1  system clock
//   reset      in  1  synchronous active-low reset, returns to FETCH1
//   op, funct  in  6  instr[31:26], instr[5:0]
//   zero       in  1  datapath equality flag
//   alucontrol, alusrca, alusrcb, iord, irwrite, memtoreg, pcen,
//   pcsource, regdst, regwrite  out  datapath controls
//   memread, memwrite           out  memory strobes
//
// state   | meaning
// FETCH1-4| read one instruction byte each, PC += 1
// DECODE  | dispatch on op, aluout <= branch target
// MEMADR  | aluout <= A + imm
// LBRD    | read memory at aluout
// LBWR    | regfile[rt] <= memory data
// SBWR    | write memory at aluout
// RTYPEEX | aluout <= A op B
// RTYPEWR | regfile[rd] <= aluout
// BEQEX   | compare, PC <= aluout when equal
// JEX     | PC <= jump target
// ADDIEX  | aluout <= A + imm (MIPS_ADDI_EN only)
// ADDIWR  | regfile[rt] <= aluout (MIPS_ADDI_EN only)
// HALT    | outputs idle until reset
module mips_controller
    import mips_ctrl_pkg::*;
#(
    parameter bit INVALID_OP_HALT = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] alucontrol,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       iord,
    output logic [3:0] irwrite,
    output logic       memtoreg,
    output logic       pcen,
    output logic [1:0] pcsource,
    output logic       regdst,
    output logic       regwrite,
    output logic       memread,
    output logic       memwrite
);

    state_t     state, state_next;
    logic       pcwrite, branch;
    logic [1:0] aluop;
    logic [2:0] alucontrol_dec;

    always_ff @(posedge clk) begin
        if (!reset) state <= FETCH1;
        else        state <= state_next;
    end

    always_comb begin
        state_next = FETCH1;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        iord       = 1'b0;
        irwrite    = 4'b0000;
        memtoreg   = 1'b0;
        pcsource   = 2'b00;
        regdst     = 1'b0;
        regwrite   = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        aluop      = ALUOP_ADD;
        case (state)
            FETCH1: begin
                memread = 1'b1; alusrcb = 2'b01; pcwrite = 1'b1; irwrite = 4'b0001;
                state_next = FETCH2;
            end
            FETCH2: begin
                memread = 1'b1; alusrcb = 2'b01; pcwrite = 1'b1; irwrite = 4'b0010;
                state_next = FETCH3;
            end
            FETCH3: begin
                memread = 1'b1; alusrcb = 2'b01; pcwrite = 1'b1; irwrite = 4'b0100;
                state_next = FETCH4;
            end
            FETCH4: begin
                memread = 1'b1; alusrcb = 2'b01; pcwrite = 1'b1; irwrite = 4'b1000;
                state_next = DECODE;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LB, OP_SB: state_next = MEMADR;
                    OP_RTYPE:     state_next = RTYPEEX;
                    OP_BEQ:       state_next = BEQEX;
                    OP_J:         state_next = JEX;
`ifdef MIPS_ADDI_EN
                    OP_ADDI:      state_next = ADDIEX;
`endif
                    default: begin
                        if (INVALID_OP_HALT) state_next = HALT;
                        else                 state_next = FETCH1;
                    end
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1; alusrcb = 2'b10;
                state_next = (op == OP_LB) ? LBRD : SBWR;
            end
            LBRD: begin
                memread = 1'b1; iord = 1'b1;
                state_next = LBWR;
            end
            LBWR: begin
                regwrite = 1'b1; memtoreg = 1'b1;
                state_next = FETCH1;
            end
            SBWR: begin
                memwrite = 1'b1; iord = 1'b1;
                state_next = FETCH1;
            end
            RTYPEEX: begin
                alusrca = 1'b1; aluop = ALUOP_FUNCT;
                state_next = RTYPEWR;
            end
            RTYPEWR: begin
                regwrite = 1'b1; regdst = 1'b1;
                state_next = FETCH1;
            end
            BEQEX: begin
                alusrca = 1'b1; aluop = ALUOP_SUB; branch = 1'b1; pcsource = 2'b01;
                state_next = FETCH1;
            end
            JEX: begin
                pcwrite = 1'b1; pcsource = 2'b10;
                state_next = FETCH1;
            end
`ifdef MIPS_ADDI_EN
            ADDIEX: begin
                alusrca = 1'b1; alusrcb = 2'b10;
                state_next = ADDIWR;
            end
            ADDIWR: begin
                regwrite = 1'b1;
                state_next = FETCH1;
            end
`endif
            HALT:    state_next = HALT;
            default: state_next = FETCH1;
        endcase
    end

    mips_aludec u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol_dec)
    );

    // HALT idles every output, including the ALU select that would
    // otherwise default to add.
    assign alucontrol = (state == HALT) ? 3'b000 : alucontrol_dec;
    assign pcen       = pcwrite | (branch & zero);

endmodule

// File: tb/tb_mips_controller.sv
// Scoreboard bench: the stimulus process pushes the expected output vector
// of every cycle; the monitor pops and compares at the falling edge.
// Two controllers share the inputs: one with INVALID_OP_HALT=0, one with 1.
module tb_mips_controller;
    import mips_ctrl_pkg::*;

    localparam int K_NONE = -1;
    localparam int K_F1 = 0, K_F2 = 1, K_F3 = 2, K_F4 = 3, K_DEC = 4, K_MEMADR = 5;
    localparam int K_LBRD = 6, K_LBWR = 7, K_SBWR = 8, K_RTEX = 9, K_RTWR = 10;
    localparam int K_BEQEX = 11, K_JEX = 12, K_ADDIEX = 13, K_ADDIWR = 14, K_HALT = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;

    logic [2:0] m_alucontrol, h_alucontrol;
    logic       m_alusrca, h_alusrca;
    logic [1:0] m_alusrcb, h_alusrcb;
    logic       m_iord, h_iord;
    logic [3:0] m_irwrite, h_irwrite;
    logic       m_memtoreg, h_memtoreg;
    logic       m_pcen, h_pcen;
    logic [1:0] m_pcsource, h_pcsource;
    logic       m_regdst, h_regdst;
    logic       m_regwrite, h_regwrite;
    logic       m_memread, h_memread;
    logic       m_memwrite, h_memwrite;

    logic [18:0] m_vec, h_vec;
    assign m_vec = {m_alucontrol, m_alusrca, m_alusrcb, m_iord, m_irwrite, m_memtoreg,
                    m_pcen, m_pcsource, m_regdst, m_regwrite, m_memread, m_memwrite};
    assign h_vec = {h_alucontrol, h_alusrca, h_alusrcb, h_iord, h_irwrite, h_memtoreg,
                    h_pcen, h_pcsource, h_regdst, h_regwrite, h_memread, h_memwrite};

    mips_controller #(.INVALID_OP_HALT(1'b0)) u_dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .alucontrol(m_alucontrol), .alusrca(m_alusrca), .alusrcb(m_alusrcb),
        .iord(m_iord), .irwrite(m_irwrite), .memtoreg(m_memtoreg), .pcen(m_pcen),
        .pcsource(m_pcsource), .regdst(m_regdst), .regwrite(m_regwrite),
        .memread(m_memread), .memwrite(m_memwrite)
    );

    mips_controller #(.INVALID_OP_HALT(1'b1)) u_dut_halt (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .alucontrol(h_alucontrol), .alusrca(h_alusrca), .alusrcb(h_alusrcb),
        .iord(h_iord), .irwrite(h_irwrite), .memtoreg(h_memtoreg), .pcen(h_pcen),
        .pcsource(h_pcsource), .regdst(h_regdst), .regwrite(h_regwrite),
        .memread(h_memread), .memwrite(h_memwrite)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [18:0] em;
        logic [18:0] eh;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    // Field order: alucontrol, alusrca, alusrcb, iord, irwrite, memtoreg,
    // pcen, pcsource, regdst, regwrite, memread, memwrite.
    function automatic logic [18:0] pack(input logic [2:0] ac, input logic asa,
                                         input logic [1:0] asb, input logic io,
                                         input logic [3:0] irw, input logic m2r,
                                         input logic pce, input logic [1:0] pcs,
                                         input logic rd, input logic rw,
                                         input logic mr, input logic mw);
        return {ac, asa, asb, io, irw, m2r, pce, pcs, rd, rw, mr, mw};
    endfunction

    function automatic logic [18:0] exp_vec(input int k, input logic z, input logic [2:0] ac_rt);
        logic [18:0] v;
        case (k)
            K_F1:     v = pack(3'b010, 1'b0, 2'b01, 1'b0, 4'b0001, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
            K_F2:     v = pack(3'b010, 1'b0, 2'b01, 1'b0, 4'b0010, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
            K_F3:     v = pack(3'b010, 1'b0, 2'b01, 1'b0, 4'b0100, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
            K_F4:     v = pack(3'b010, 1'b0, 2'b01, 1'b0, 4'b1000, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
            K_DEC:    v = pack(3'b010, 1'b0, 2'b11, 1'b0, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
            K_MEMADR: v = pack(3'b010, 1'b1, 2'b10, 1'b0, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
            K_LBRD:   v = pack(3'b010, 1'b0, 2'b00, 1'b1, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
            K_LBWR:   v = pack(3'b010, 1'b0, 2'b00, 1'b0, 4'b0000, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
            K_SBWR:   v = pack(3'b010, 1'b0, 2'b00, 1'b1, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
            K_RTEX:   v = pack(ac_rt,  1'b1, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
            K_RTWR:   v = pack(3'b010, 1'b0, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
            K_BEQEX:  v = pack(3'b110, 1'b1, 2'b00, 1'b0, 4'b0000, 1'b0, z,    2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
            K_JEX:    v = pack(3'b010, 1'b0, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
            K_ADDIEX: v = pack(3'b010, 1'b1, 2'b10, 1'b0, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
            K_ADDIWR: v = pack(3'b010, 1'b0, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
            default:  v = '0;
        endcase
        return v;
    endfunction

    task automatic cyc(input string nm, input int km, input int kh, input logic rst_v,
                       input logic [5:0] op_v, input logic [5:0] fn_v, input logic z_v,
                       input logic [2:0] ac_rt);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst_v;
        op    = op_v;
        funct = fn_v;
        zero  = z_v;
        e.nm = nm;
        e.em = exp_vec(km, z_v, ac_rt);
        e.eh = exp_vec(kh, z_v, ac_rt);
        q.push_back(e);
    endtask

    // One full instruction starting at FETCH1; s1..s3 are the states after
    // DECODE. rst_last pulls reset low during the final state.
    task automatic instr(input string nm, input logic [5:0] op_v, input logic [5:0] fn_v,
                         input logic z_v, input logic [2:0] ac_rt,
                         input int s1, input int s2, input int s3, input bit rst_last);
        int path[$];
        path = '{K_F1, K_F2, K_F3, K_F4, K_DEC};
        if (s1 != K_NONE) path.push_back(s1);
        if (s2 != K_NONE) path.push_back(s2);
        if (s3 != K_NONE) path.push_back(s3);
        for (int i = 0; i < path.size(); i++)
            cyc($sformatf("%s_c%0d", nm, i), path[i], path[i],
                (rst_last && i == path.size() - 1) ? 1'b0 : 1'b1, op_v, fn_v, z_v, ac_rt);
    endtask

    // Unknown opcode: the default controller refetches, the halting one
    // parks in HALT until reset, which is applied in the last cycle here.
    task automatic run_invalid(input string nm, input logic [5:0] op_v);
        cyc({nm, "_f1"},  K_F1,  K_F1,   1'b1, op_v, 6'd0, 1'b0, 3'b010);
        cyc({nm, "_f2"},  K_F2,  K_F2,   1'b1, op_v, 6'd0, 1'b0, 3'b010);
        cyc({nm, "_f3"},  K_F3,  K_F3,   1'b1, op_v, 6'd0, 1'b0, 3'b010);
        cyc({nm, "_f4"},  K_F4,  K_F4,   1'b1, op_v, 6'd0, 1'b0, 3'b010);
        cyc({nm, "_dec"}, K_DEC, K_DEC,  1'b1, op_v, 6'd0, 1'b0, 3'b010);
        cyc({nm, "_h1"},  K_F1,  K_HALT, 1'b1, op_v, 6'd0, 1'b0, 3'b010);
        cyc({nm, "_h2"},  K_F2,  K_HALT, 1'b1, op_v, 6'd0, 1'b0, 3'b010);
        cyc({nm, "_h3"},  K_F3,  K_HALT, 1'b0, op_v, 6'd0, 1'b0, 3'b010);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (m_vec !== e.em) begin
                failures++;
                $display("FAIL %s dut actual=%b required=%b", e.nm, m_vec, e.em);
            end
            checks++;
            if (h_vec !== e.eh) begin
                failures++;
                $display("FAIL %s dut_halt actual=%b required=%b", e.nm, h_vec, e.eh);
            end
        end
    end

    initial begin
        cyc("rst_a", K_F1, K_F1, 1'b0, 6'd0, 6'd0, 1'b0, 3'b010);
        cyc("rst_b", K_F1, K_F1, 1'b0, 6'd0, 6'd0, 1'b0, 3'b010);
        instr("r_sub",  OP_RTYPE, 6'b100010, 1'b0, 3'b110, K_RTEX, K_RTWR, K_NONE, 1'b0);
        instr("r_and",  OP_RTYPE, 6'b100100, 1'b0, 3'b000, K_RTEX, K_RTWR, K_NONE, 1'b0);
        instr("r_or",   OP_RTYPE, 6'b100101, 1'b1, 3'b001, K_RTEX, K_RTWR, K_NONE, 1'b0);
        instr("r_slt",  OP_RTYPE, 6'b101010, 1'b0, 3'b111, K_RTEX, K_RTWR, K_NONE, 1'b0);
        instr("r_add",  OP_RTYPE, 6'b100000, 1'b0, 3'b010, K_RTEX, K_RTWR, K_NONE, 1'b0);
        instr("r_unk",  OP_RTYPE, 6'b000111, 1'b0, 3'b010, K_RTEX, K_RTWR, K_NONE, 1'b0);
        instr("lb",     6'b100000, 6'b100010, 1'b0, 3'b010, K_MEMADR, K_LBRD, K_LBWR, 1'b0);
        instr("sb",     6'b101000, 6'b100010, 1'b0, 3'b010, K_MEMADR, K_SBWR, K_NONE, 1'b0);
        instr("beq_z1", 6'b000100, 6'b000000, 1'b1, 3'b010, K_BEQEX, K_NONE, K_NONE, 1'b0);
        instr("beq_z0", 6'b000100, 6'b000000, 1'b0, 3'b010, K_BEQEX, K_NONE, K_NONE, 1'b0);
        instr("j",      6'b000010, 6'b000000, 1'b1, 3'b010, K_JEX, K_NONE, K_NONE, 1'b0);
        // reset in the middle of fetch: FETCH1 follows FETCH3
        cyc("mf_f1", K_F1, K_F1, 1'b1, 6'b000010, 6'd0, 1'b0, 3'b010);
        cyc("mf_f2", K_F2, K_F2, 1'b1, 6'b000010, 6'd0, 1'b0, 3'b010);
        cyc("mf_f3", K_F3, K_F3, 1'b0, 6'b000010, 6'd0, 1'b0, 3'b010);
`ifdef MIPS_ADDI_EN
        instr("addi",   6'b001000, 6'b000000, 1'b0, 3'b010, K_ADDIEX, K_ADDIWR, K_NONE, 1'b0);
`else
        run_invalid("addi_off", 6'b001000);
`endif
        run_invalid("bad_op", 6'b111111);
        instr("sb_rst", 6'b101000, 6'b000000, 1'b0, 3'b010, K_MEMADR, K_SBWR, K_NONE, 1'b1);
        instr("j_post", 6'b000010, 6'b000000, 1'b0, 3'b010, K_JEX, K_NONE, K_NONE, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d pending required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
